// File: rtl/arp_data_rx.sv
// ARP payload receiver: walks the 28-byte ARP body after the Ethernet header,
// validates the fixed fields and publishes sender/target addresses per packet.
//
// state              | meaning
// -------------------+---------------------------------------------------
// WAIT_START         | idle, waiting for eth_header_arp_done
// HTYPE_RX           | hardware type, 2 bytes, expect 0x0001
// PTYPE_RX           | protocol type, 2 bytes, expect 0x0800
// HLEN_RX            | hardware address length, 1 byte, expect 0x06
// PLEN_RX            | protocol address length, 1 byte, expect 0x04
// OPER_RX            | operation, 2 bytes, 0x0001 request / 0x0002 reply
// MAC_SOURCE_RX      | sender hardware address, 6 bytes
// IP_SOURCE_RX       | sender protocol address, 4 bytes
// MAC_DESTINATION_RX | target hardware address, 6 bytes
// IP_DESTINATION_RX  | target protocol address, 4 bytes; last byte completes

module arp_data_rx #(
    parameter bit CHECK_HDR = 1'b1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        eth_header_arp_done,
    input  logic        data_valid,
    input  logic [7:0]  data_in,
    input  logic        frame_abort,
    input  logic [31:0] local_ip,
    output logic        arp_oper,
    output logic [47:0] mac_s_addr,
    output logic [31:0] ip_s_addr,
    output logic [47:0] mac_d_addr,
    output logic [31:0] ip_d_addr,
    output logic        ip_match,
    output logic        arp_data_done,
    output logic        arp_data_err
);

    typedef enum logic [3:0] {
        WAIT_START,
        HTYPE_RX,
        PTYPE_RX,
        HLEN_RX,
        PLEN_RX,
        OPER_RX,
        MAC_SOURCE_RX,
        IP_SOURCE_RX,
        MAC_DESTINATION_RX,
        IP_DESTINATION_RX
    } state_t;

    state_t      state;
    logic [2:0]  byte_cnt;   // bytes left in the current field minus one
    logic        err_flag;
    logic        oper_sh;
    logic [47:0] mac_s_sh;
    logic [31:0] ip_s_sh;
    logic [47:0] mac_d_sh;
    logic [31:0] ip_d_sh;
    logic        byte_bad;
    logic [31:0] ip_d_full;

    assign ip_d_full = {ip_d_sh[23:0], data_in};

    // byte_cnt != 0 marks the first (high) byte of a two-byte field
    always_comb begin
        byte_bad = 1'b0;
        case (state)
            HTYPE_RX: byte_bad = CHECK_HDR &&
                                 (data_in != ((byte_cnt != 3'd0) ? 8'h00 : 8'h01));
            PTYPE_RX: byte_bad = CHECK_HDR &&
                                 (data_in != ((byte_cnt != 3'd0) ? 8'h08 : 8'h00));
            HLEN_RX:  byte_bad = CHECK_HDR && (data_in != 8'h06);
            PLEN_RX:  byte_bad = CHECK_HDR && (data_in != 8'h04);
            OPER_RX:  byte_bad = (byte_cnt != 3'd0) ? (data_in != 8'h00)
                                 : ((data_in != 8'h01) && (data_in != 8'h02));
            default:  byte_bad = 1'b0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= WAIT_START;
            byte_cnt      <= 3'd0;
            err_flag      <= 1'b0;
            oper_sh       <= 1'b0;
            mac_s_sh      <= 48'h0;
            ip_s_sh       <= 32'h0;
            mac_d_sh      <= 48'h0;
            ip_d_sh       <= 32'h0;
            arp_oper      <= 1'b0;
            mac_s_addr    <= 48'h0;
            ip_s_addr     <= 32'h0;
            mac_d_addr    <= 48'h0;
            ip_d_addr     <= 32'h0;
            ip_match      <= 1'b0;
            arp_data_done <= 1'b0;
            arp_data_err  <= 1'b0;
        end else begin
            arp_data_done <= 1'b0;
            arp_data_err  <= 1'b0;

            if (state != WAIT_START && frame_abort) begin
                state        <= WAIT_START;
                byte_cnt     <= 3'd0;
                err_flag     <= 1'b0;
                arp_data_err <= 1'b1;
            end else if (eth_header_arp_done) begin
                state    <= HTYPE_RX;
                byte_cnt <= 3'd1;
                err_flag <= 1'b0;
            end else if (state != WAIT_START && data_valid) begin
                if (byte_bad) begin
                    err_flag <= 1'b1;
                end

                case (state)
                    OPER_RX:            oper_sh  <= (data_in == 8'h01);
                    MAC_SOURCE_RX:      mac_s_sh <= {mac_s_sh[39:0], data_in};
                    IP_SOURCE_RX:       ip_s_sh  <= {ip_s_sh[23:0], data_in};
                    MAC_DESTINATION_RX: mac_d_sh <= {mac_d_sh[39:0], data_in};
                    IP_DESTINATION_RX:  ip_d_sh  <= ip_d_full;
                    default: ;
                endcase

                if (byte_cnt != 3'd0) begin
                    byte_cnt <= byte_cnt - 3'd1;
                end else begin
                    case (state)
                        HTYPE_RX: begin
                            state    <= PTYPE_RX;
                            byte_cnt <= 3'd1;
                        end
                        PTYPE_RX: begin
                            state    <= HLEN_RX;
                            byte_cnt <= 3'd0;
                        end
                        HLEN_RX: begin
                            state    <= PLEN_RX;
                            byte_cnt <= 3'd0;
                        end
                        PLEN_RX: begin
                            state    <= OPER_RX;
                            byte_cnt <= 3'd1;
                        end
                        OPER_RX: begin
                            state    <= MAC_SOURCE_RX;
                            byte_cnt <= 3'd5;
                        end
                        MAC_SOURCE_RX: begin
                            state    <= IP_SOURCE_RX;
                            byte_cnt <= 3'd3;
                        end
                        IP_SOURCE_RX: begin
                            state    <= MAC_DESTINATION_RX;
                            byte_cnt <= 3'd5;
                        end
                        MAC_DESTINATION_RX: begin
                            state    <= IP_DESTINATION_RX;
                            byte_cnt <= 3'd3;
                        end
                        IP_DESTINATION_RX: begin
                            state    <= WAIT_START;
                            err_flag <= 1'b0;
                            if (err_flag || byte_bad) begin
                                arp_data_err <= 1'b1;
                            end else begin
                                arp_oper      <= oper_sh;
                                mac_s_addr    <= mac_s_sh;
                                ip_s_addr     <= ip_s_sh;
                                mac_d_addr    <= mac_d_sh;
                                ip_d_addr     <= ip_d_full;
                                ip_match      <= (ip_d_full == local_ip);
                                arp_data_done <= 1'b1;
                            end
                        end
                        default: state <= WAIT_START;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_arp_data_rx.sv
// Directed bench for arp_data_rx: one instance with header checking, one without,
// driven by shared stimulus from a vector table plus hand-written corner sequences.

module tb_arp_data_rx;

    logic        aclk = 1'b0;
    logic        areset;
    logic        eth_header_arp_done;
    logic        data_valid;
    logic [7:0]  data_in;
    logic        frame_abort;
    logic [31:0] local_ip;

    logic        oper1, match1, done1, err1;
    logic [47:0] mac_s1, mac_d1;
    logic [31:0] ip_s1, ip_d1;
    logic        oper0, match0, done0, err0;
    logic [47:0] mac_s0, mac_d0;
    logic [31:0] ip_s0, ip_d0;

    always #5 aclk = ~aclk;

    arp_data_rx #(.CHECK_HDR(1'b1)) u_dut (
        .aclk(aclk), .areset(areset), .eth_header_arp_done(eth_header_arp_done),
        .data_valid(data_valid), .data_in(data_in), .frame_abort(frame_abort),
        .local_ip(local_ip), .arp_oper(oper1), .mac_s_addr(mac_s1), .ip_s_addr(ip_s1),
        .mac_d_addr(mac_d1), .ip_d_addr(ip_d1), .ip_match(match1),
        .arp_data_done(done1), .arp_data_err(err1)
    );

    arp_data_rx #(.CHECK_HDR(1'b0)) u_dut_nochk (
        .aclk(aclk), .areset(areset), .eth_header_arp_done(eth_header_arp_done),
        .data_valid(data_valid), .data_in(data_in), .frame_abort(frame_abort),
        .local_ip(local_ip), .arp_oper(oper0), .mac_s_addr(mac_s0), .ip_s_addr(ip_s0),
        .mac_d_addr(mac_d0), .ip_d_addr(ip_d0), .ip_match(match0),
        .arp_data_done(done0), .arp_data_err(err0)
    );

    typedef struct {
        logic [15:0] htype;
        logic [7:0]  plen;
        logic [15:0] oper;
        logic [47:0] mac_s;
        logic [31:0] ip_s;
        logic [47:0] mac_d;
        logic [31:0] ip_d;
        logic [31:0] lip;
        bit          gaps;
        bit          done1;
        bit          done0;
        bit          oper1;
        bit          match1;
        bit          oper0;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0]  pkt [28];
    logic [47:0] m1_mac_s = '0, m1_mac_d = '0, m0_mac_s = '0;
    logic [31:0] m1_ip_s = '0, m1_ip_d = '0, m0_ip_d = '0;
    int mon_d1 = 0, mon_e1 = 0, mon_d0 = 0, mon_e0 = 0;
    int exp_d1 = 0, exp_e1 = 0, exp_d0 = 0, exp_e0 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (done1) mon_d1++;
        if (err1)  mon_e1++;
        if (done0) mon_d0++;
        if (err0)  mon_e0++;
        if (!areset) chk("done_err_exclusive", {62'h0, done1, err1} == 64'h3, 64'h0);
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic build_pkt(input vec_t v);
        pkt[0] = v.htype[15:8]; pkt[1] = v.htype[7:0];
        pkt[2] = 8'h08;         pkt[3] = 8'h00;
        pkt[4] = 8'h06;         pkt[5] = v.plen;
        pkt[6] = v.oper[15:8];  pkt[7] = v.oper[7:0];
        for (int i = 0; i < 6; i++) pkt[8 + i]  = v.mac_s[47 - 8*i -: 8];
        for (int i = 0; i < 4; i++) pkt[14 + i] = v.ip_s[31 - 8*i -: 8];
        for (int i = 0; i < 6; i++) pkt[18 + i] = v.mac_d[47 - 8*i -: 8];
        for (int i = 0; i < 4; i++) pkt[24 + i] = v.ip_d[31 - 8*i -: 8];
        local_ip = v.lip;
    endtask

    // A byte is offered alongside the pulse; it must be ignored.
    task automatic start_pulse();
        eth_header_arp_done = 1'b1;
        data_valid = 1'b1;
        data_in = 8'hFF;
        @(posedge aclk); #1;
        eth_header_arp_done = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic send_bytes(input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) begin
            if (gaps) begin
                repeat ($urandom_range(1, 0)) begin
                    data_valid = 1'b0;
                    data_in = 8'($urandom_range(255, 0));
                    @(posedge aclk); #1;
                end
            end
            data_valid = 1'b1;
            data_in = pkt[i];
            @(posedge aclk); #1;
        end
        data_valid = 1'b0;
    endtask

    // Called #1 after the edge that accepted byte 28.
    task automatic finish_pkt(input string name, input vec_t v, input bit d1, input bit d0,
                              input bit eo1, input bit em1, input bit eo0);
        chk({name, " done1"}, done1, d1);
        chk({name, " err1"},  err1, !d1);
        chk({name, " done0"}, done0, d0);
        chk({name, " err0"},  err0, !d0);
        if (d1) begin
            m1_mac_s = v.mac_s; m1_ip_s = v.ip_s; m1_mac_d = v.mac_d; m1_ip_d = v.ip_d;
            exp_d1++;
        end else exp_e1++;
        if (d0) begin
            m0_mac_s = v.mac_s; m0_ip_d = v.ip_d;
            exp_d0++;
        end else exp_e0++;
        chk({name, " oper1"},  oper1, eo1);
        chk({name, " match1"}, match1, em1);
        chk({name, " mac_s1"}, mac_s1, m1_mac_s);
        chk({name, " ip_s1"},  ip_s1, m1_ip_s);
        chk({name, " mac_d1"}, mac_d1, m1_mac_d);
        chk({name, " ip_d1"},  ip_d1, m1_ip_d);
        chk({name, " oper0"},  oper0, eo0);
        chk({name, " mac_s0"}, mac_s0, m0_mac_s);
        chk({name, " ip_d0"},  ip_d0, m0_ip_d);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " outs1"}, {oper1, match1, done1, err1, mac_s1 | mac_d1, ip_s1 | ip_d1}, 64'h0);
        chk({name, " outs0"}, {oper0, match0, done0, err0, mac_s0 | mac_d0, ip_s0 | ip_d0}, 64'h0);
    endtask

    vec_t vecs [6];
    vec_t va, vb;

    initial begin
        vecs[0] = '{16'h0001, 8'h04, 16'h0001, 48'h020000000001, 32'hC0A8010A,
                    48'h000000000000, 32'hC0A80102, 32'hC0A80102, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{16'h0001, 8'h04, 16'h0002, 48'h020000000002, 32'hC0A80105,
                    48'h112233445566, 32'hC0A80163, 32'hC0A80102, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h0002, 8'h04, 16'h0001, 48'hDEADBEEF0001, 32'h0A000001,
                    48'h000000000000, 32'hC0A80102, 32'hC0A80102, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'h0001, 8'h04, 16'h0003, 48'hDEADBEEF0002, 32'h0A000002,
                    48'h000000000000, 32'hC0A80102, 32'hC0A80102, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'h0001, 8'h04, 16'h0001, 48'h020000000001, 32'hC0A8010A,
                    48'h000000000000, 32'hC0A80102, 32'hC0A80102, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{16'h0001, 8'h05, 16'h0002, 48'h0A0B0C0D0E0F, 32'h0A000003,
                    48'h000000000001, 32'hC0A80102, 32'hC0A80102, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        va = '{16'h0001, 8'h04, 16'h0001, 48'h0200000000AA, 32'hC0A80120,
               48'h000000000000, 32'hC0A80102, 32'hC0A80102, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vb = '{16'h0001, 8'h04, 16'h0002, 48'h0200000000BB, 32'hC0A80121,
               48'hAABBCCDDEEFF, 32'hC0A80102, 32'hC0A80102, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        areset = 1'b1;
        eth_header_arp_done = 1'b0;
        data_valid = 1'b0;
        data_in = 8'h00;
        frame_abort = 1'b0;
        local_ip = 32'h0;
        repeat (3) @(posedge aclk);
        #1;
        chk_all_zero("reset");
        areset = 1'b0;
        @(posedge aclk); #1;

        // Table: packets run back-to-back, each pulse in the cycle after done.
        for (int i = 0; i < 6; i++) begin
            build_pkt(vecs[i]);
            start_pulse();
            send_bytes(0, 27, vecs[i].gaps);
            finish_pkt($sformatf("vec%0d", i), vecs[i], vecs[i].done1, vecs[i].done0,
                       vecs[i].oper1, vecs[i].match1, vecs[i].oper0);
        end

        // Abort at byte 12.
        build_pkt(va);
        start_pulse();
        send_bytes(0, 10, 1'b0);
        data_valid = 1'b1; data_in = pkt[11]; frame_abort = 1'b1;
        @(posedge aclk); #1;
        frame_abort = 1'b0; data_valid = 1'b0;
        chk("abort12 err1", err1, 1'b1);
        chk("abort12 done1", done1, 1'b0);
        chk("abort12 err0", err0, 1'b1);
        chk("abort12 mac_s1 held", mac_s1, m1_mac_s);
        exp_e1++; exp_e0++;
        // Idle stream without a start pulse must be ignored in WAIT_START.
        send_bytes(0, 27, 1'b0);
        chk("abort12 idle done1", done1, 1'b0);
        start_pulse();
        send_bytes(0, 27, 1'b0);
        finish_pkt("abort_recover", va, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Abort coinciding with byte 28.
        build_pkt(vb);
        start_pulse();
        send_bytes(0, 26, 1'b0);
        data_valid = 1'b1; data_in = pkt[27]; frame_abort = 1'b1;
        @(posedge aclk); #1;
        frame_abort = 1'b0; data_valid = 1'b0;
        chk("abort28 err1", err1, 1'b1);
        chk("abort28 done1", done1, 1'b0);
        chk("abort28 err0", err0, 1'b1);
        chk("abort28 done0", done0, 1'b0);
        chk("abort28 mac_s1 held", mac_s1, m1_mac_s);
        exp_e1++; exp_e0++;
        frame_abort = 1'b1;
        @(posedge aclk); #1;
        frame_abort = 1'b0;
        chk("idle abort err1", err1, 1'b0);

        // Restart mid-packet, then back-to-back packet.
        start_pulse();
        send_bytes(0, 7, 1'b0);
        start_pulse();
        chk("restart no err1", err1, 1'b0);
        send_bytes(0, 27, 1'b0);
        finish_pkt("restart", vb, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        build_pkt(vecs[1]);
        start_pulse();
        send_bytes(0, 27, 1'b0);
        finish_pkt("b2b", vecs[1], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset at byte 20.
        build_pkt(vecs[0]);
        start_pulse();
        send_bytes(0, 18, 1'b0);
        data_valid = 1'b1; data_in = pkt[19]; areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0; data_valid = 1'b0;
        chk_all_zero("reset20");
        m1_mac_s = '0; m1_ip_s = '0; m1_mac_d = '0; m1_ip_d = '0;
        m0_mac_s = '0; m0_ip_d = '0;
        send_bytes(20, 27, 1'b0);
        chk("reset20 no done1", done1, 1'b0);
        chk("reset20 no err1", err1, 1'b0);
        start_pulse();
        send_bytes(0, 27, 1'b1);
        finish_pkt("after_reset", vecs[0], 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        @(posedge aclk); #1;
        chk("pulse count done1", mon_d1, exp_d1);
        chk("pulse count err1", mon_e1, exp_e1);
        chk("pulse count done0", mon_d0, exp_d0);
        chk("pulse count err0", mon_e0, exp_e0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arp_data_rx.md
Name: arp_data_rx

Overview:
- Receive-side ARP payload parser; the receive counterpart of the ARP payload transmitter.
- Sits after the Ethernet header receiver, which pulses eth_header_arp_done once the EtherType 0x0806 header has been consumed.
- Consumes the 28-byte ARP body one byte per accepted cycle and validates the fixed fields (HTYPE, PTYPE, HLEN, PLEN, OPER).
- Publishes sender/target MAC and IP plus the operation to the ARP controller, with a done or error pulse per packet.

Parameters:
- CHECK_HDR, 1, when 1 a HTYPE/PTYPE/HLEN/PLEN/OPER mismatch produces arp_data_err; when 0 only OPER is checked.

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous reset, active-high
- eth_header_arp_done  in  1  one-cycle pulse; ARP body bytes follow from the next cycle
- data_valid  in  1  data_in carries a valid byte this cycle
- data_in  in  8  ARP byte stream, network order, MSB byte first
- frame_abort  in  1  upstream frame error or early end; discards the current packet
- local_ip  in  32  own IPv4 address, used for the match compare
- arp_oper  out  1  1 = request (OPER 0x0001), 0 = reply (OPER 0x0002)
- mac_s_addr  out  48  sender hardware address
- ip_s_addr  out  32  sender protocol address
- mac_d_addr  out  48  target hardware address
- ip_d_addr  out  32  target protocol address
- ip_match  out  1  ip_d_addr == local_ip, sampled at completion
- arp_data_done  out  1  one-cycle pulse: good packet; field outputs updated
- arp_data_err  out  1  one-cycle pulse: packet rejected or aborted

Behaviour:
- Reset: state = WAIT_START, byte counter = 0, error flag = 0, every output = 0.
- States: WAIT_START, HTYPE_RX(2), PTYPE_RX(2), HLEN_RX(1), PLEN_RX(1), OPER_RX(2), MAC_SOURCE_RX(6), IP_SOURCE_RX(4), MAC_DESTINATION_RX(6), IP_DESTINATION_RX(4). The number in brackets is the byte count; 28 bytes in total.
- WAIT_START -> HTYPE_RX on eth_header_arp_done. Bytes with data_valid in the same cycle as the pulse are ignored.
- In receive states, the counter and state advance only on data_valid = 1. Gaps of any length are allowed.
- Multi-byte fields are shifted in MSB-first into shadow registers: the first byte lands in bits [47:40] or [31:24].
- Field checks run as each byte arrives:
  - HTYPE must be 0x0001, PTYPE 0x0800, HLEN 0x06, PLEN 0x04.
  - OPER must be 0x0001 or 0x0002, regardless of CHECK_HDR.
  - A failed check sets a sticky error flag. Reception continues to byte 28 so stream alignment is kept.
- Completion: byte 28 is accepted at edge N. From edge N, for exactly one cycle:
  - Error flag clear: shadow fields are copied to the outputs, ip_match is updated, arp_data_done = 1.
  - Error flag set: outputs keep their previous values and arp_data_err = 1.
  - The state returns to WAIT_START and the error flag clears.
- Outputs change only on a good completion or on reset. They hold the last good packet indefinitely.
- frame_abort in any receive state: the next state is WAIT_START, arp_data_err pulses for one cycle, and the shadow data is discarded. frame_abort in WAIT_START has no effect.
- eth_header_arp_done while busy (without abort): restart at HTYPE_RX with the counter and error flag cleared. No pulse is emitted for the discarded packet.
- frame_abort and eth_header_arp_done in the same cycle: abort takes priority (err pulse, WAIT_START).
- Byte 28 and frame_abort in the same cycle: abort wins; no done pulse.
- arp_data_done and arp_data_err are never high together.
- An eth_header_arp_done pulse arriving in the completion cycle's next cycle is accepted, so back-to-back packets are supported.
- Reset mid-packet: immediate return to the reset values; no pulses.

Test Plan:
- Request: 00 01 08 00 06 04 00 01, sender 02:00:00:00:00:01 / 192.168.1.10, target 00:..:00 / 192.168.1.2, local_ip = C0A80102 -> arp_data_done for one cycle after byte 28; arp_oper = 1, ip_s_addr = C0A8010A, mac_s_addr = 020000000001, ip_match = 1.
- Reply, OPER 00 02, target IP 192.168.1.99 -> arp_oper = 0, ip_match = 0, mac_d_addr equal to the sent bytes.
- HTYPE = 00 02 with CHECK_HDR = 1 -> all 28 bytes consumed, arp_data_err pulses, outputs unchanged from the previous test. The same stimulus with CHECK_HDR = 0 -> done. OPER = 00 03 -> err in both cases.
- data_valid toggled randomly (about 50%) across a request -> identical fields to the first test; done occurs exactly one cycle after the last valid byte.
- frame_abort at byte 12 -> err pulse, WAIT_START. A following good packet completes correctly. Abort together with byte 28 -> err only, no done.
- Back-to-back packets with the second pulse right after done -> two done pulses, and the second packet's fields are latched. Reset asserted at byte 20 -> all outputs 0, no pulse.
